// File: rtl/half_adder_bank.sv
// Bank of WIDTH independent half adders with a registered result copy and a
// saturating carry-event counter. Define HALF_ADDER_BANK_PARITY_EN to add Parity_q.
module half_adder_bank #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             In_valid,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Carry,
  output logic [WIDTH-1:0] Sum_q,
  output logic [WIDTH-1:0] Carry_q,
  output logic             Out_valid,
  output logic [CNT_W-1:0] Carry_cnt
`ifdef HALF_ADDER_BANK_PARITY_EN
  ,
  output logic             Parity_q
`endif
);

  localparam int unsigned PC_W  = $clog2(WIDTH + 1);
  localparam int unsigned ACC_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PC_W-1:0]  carry_pop;
  logic [ACC_W-1:0] cnt_acc;
  logic [CNT_W-1:0] cnt_next;

  assign Sum   = A ^ B;
  assign Carry = A & B;

  // Number of lanes producing a carry this beat
  always_comb begin
    carry_pop = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      carry_pop = carry_pop + PC_W'(Carry[i]);
    end
  end

  // One extra accumulator bit lets overflow be detected before clamping
  always_comb begin
    cnt_acc  = ACC_W'(Carry_cnt) + ACC_W'(carry_pop);
    cnt_next = (cnt_acc > ACC_W'(CNT_MAX)) ? CNT_MAX : cnt_acc[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Sum_q     <= '0;
      Carry_q   <= '0;
      Out_valid <= 1'b0;
      Carry_cnt <= '0;
    end else begin
      Out_valid <= In_valid;
      if (In_valid) begin
        Sum_q     <= Sum;
        Carry_q   <= Carry;
        Carry_cnt <= cnt_next;
      end
    end
  end

`ifdef HALF_ADDER_BANK_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      Parity_q <= 1'b0;
    end else if (In_valid) begin
      Parity_q <= ^{Sum, Carry};
    end
  end
`endif

endmodule

// File: tb/tb_half_adder_bank.sv
// Directed self-checking bench for half_adder_bank across several parameter sets.
// Define HALF_ADDER_BANK_PARITY_EN to also exercise Parity_q.
module tb_half_adder_bank;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  // WIDTH=1, default counter
  logic        a1, b1, v1, s1, c1, sq1, cq1, ov1;
  logic [15:0] cnt1;
  // WIDTH=4
  logic [3:0]  a4, b4, s4, c4, sq4, cq4;
  logic        v4, ov4;
  logic [15:0] cnt4;
  // WIDTH=1, CNT_W=2 for saturation
  logic        as, bs, vs, ss, cs, sqs, cqs, ovs;
  logic [1:0]  cnts;
`ifdef HALF_ADDER_BANK_PARITY_EN
  logic        p1, p4, ps, p2, v2, ov2;
  logic [1:0]  a2, b2, s2, c2, sq2, cq2;
  logic [15:0] cnt2;
`endif

  half_adder_bank #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .In_valid(v1),
    .Sum(s1), .Carry(c1), .Sum_q(sq1), .Carry_q(cq1),
    .Out_valid(ov1), .Carry_cnt(cnt1)
`ifdef HALF_ADDER_BANK_PARITY_EN
    , .Parity_q(p1)
`endif
  );

  half_adder_bank #(.WIDTH(4), .CNT_W(16)) u_w4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .In_valid(v4),
    .Sum(s4), .Carry(c4), .Sum_q(sq4), .Carry_q(cq4),
    .Out_valid(ov4), .Carry_cnt(cnt4)
`ifdef HALF_ADDER_BANK_PARITY_EN
    , .Parity_q(p4)
`endif
  );

  half_adder_bank #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .A(as), .B(bs), .In_valid(vs),
    .Sum(ss), .Carry(cs), .Sum_q(sqs), .Carry_q(cqs),
    .Out_valid(ovs), .Carry_cnt(cnts)
`ifdef HALF_ADDER_BANK_PARITY_EN
    , .Parity_q(ps)
`endif
  );

`ifdef HALF_ADDER_BANK_PARITY_EN
  half_adder_bank #(.WIDTH(2), .CNT_W(16)) u_w2 (
    .clk(clk), .rst(rst), .A(a2), .B(b2), .In_valid(v2),
    .Sum(s2), .Carry(c2), .Sum_q(sq2), .Carry_q(cq2),
    .Out_valid(ov2), .Carry_cnt(cnt2), .Parity_q(p2)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one rising edge and land just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] tt_sum;
    logic [3:0] tt_carry;
    logic [1:0] exp_sat;
    tt_sum   = 4'b0110;
    tt_carry = 4'b1000;

    rst = 1'b1;
    {a1, b1, v1} = '0;
    {a4, b4, v4} = '0;
    {as, bs, vs} = '0;
`ifdef HALF_ADDER_BANK_PARITY_EN
    {a2, b2, v2} = '0;
`endif
    step();
    step();
    check("rst_sum_q",   32'(sq1),  32'd0);
    check("rst_carry_q", 32'(cq1),  32'd0);
    check("rst_out_vld", 32'(ov1),  32'd0);
    check("rst_cnt",     32'(cnt1), 32'd0);

    // Truth table, first under reset and then with In_valid low
    for (int pass = 0; pass < 2; pass++) begin
      for (int v = 0; v < 4; v++) begin
        a1 = v[1];
        b1 = v[0];
        #10;
        check($sformatf("tt_sum_p%0d_%0d", pass, v),   32'(s1), 32'(tt_sum[v]));
        check($sformatf("tt_carry_p%0d_%0d", pass, v), 32'(c1), 32'(tt_carry[v]));
      end
      rst = 1'b0;
      step();
    end
    check("idle_cnt", 32'(cnt1), 32'd0);

    // Single accepted beat then hold
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    step();
    check("acc_sum_q",   32'(sq1),  32'd0);
    check("acc_carry_q", 32'(cq1),  32'd1);
    check("acc_out_vld", 32'(ov1),  32'd1);
    check("acc_cnt",     32'(cnt1), 32'd1);
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b0;
    step();
    check("hold_sum_q",   32'(sq1),  32'd0);
    check("hold_carry_q", 32'(cq1),  32'd1);
    check("hold_out_vld", 32'(ov1),  32'd0);
    check("hold_cnt",     32'(cnt1), 32'd1);

    // WIDTH=4 lanes are independent; counter adds popcount
    a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
    #1;
    check("w4_sum",   32'(s4), 32'h6);
    check("w4_carry", 32'(c4), 32'h8);
    step();
    check("w4_sum_q",   32'(sq4),  32'h6);
    check("w4_carry_q", 32'(cq4),  32'h8);
    check("w4_cnt1",    32'(cnt4), 32'd1);
    a4 = 4'b1111; b4 = 4'b1111;
    step();
    check("w4_sum_q2",   32'(sq4),  32'h0);
    check("w4_carry_q2", 32'(cq4),  32'hf);
    check("w4_cnt5",     32'(cnt4), 32'd5);
    v4 = 1'b0;
    step();
    check("w4_cnt_hold", 32'(cnt4), 32'd5);
    check("w4_ov_low",   32'(ov4),  32'd0);

    // Two-bit counter saturates at 3
    as = 1'b1; bs = 1'b1; vs = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      exp_sat = (k < 3) ? 2'(k + 1) : 2'd3;
      check($sformatf("sat_cnt_%0d", k), 32'(cnts), 32'(exp_sat));
    end

    // Reset wins over a valid beat; combinational path stays live
    rst = 1'b1; a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    #1;
    check("rstv_carry_pre", 32'(c1), 32'd1);
    step();
    check("rstv_sum_q",   32'(sq1),  32'd0);
    check("rstv_carry_q", 32'(cq1),  32'd0);
    check("rstv_out_vld", 32'(ov1),  32'd0);
    check("rstv_cnt",     32'(cnt1), 32'd0);
    check("rstv_sat_cnt", 32'(cnts), 32'd0);
    check("rstv_carry",   32'(c1),   32'd1);
    check("rstv_sum",     32'(s1),   32'd0);
    rst = 1'b0;
    step();
    check("post_rst_cnt", 32'(cnt1), 32'd1);

`ifdef HALF_ADDER_BANK_PARITY_EN
    check("par_rst", 32'(p2), 32'd0);
    a2 = 2'b11; b2 = 2'b01; v2 = 1'b1;
    step();
    check("par_sum_q",   32'(sq2), 32'h2);
    check("par_carry_q", 32'(cq2), 32'h1);
    check("par_even",    32'(p2),  32'd0);
    a2 = 2'b01; b2 = 2'b00;
    step();
    check("par_odd", 32'(p2), 32'd1);
    v2 = 1'b0; a2 = 2'b11; b2 = 2'b01;
    step();
    check("par_hold", 32'(p2), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
